pred_alu_pipe: RTL and testbench
================================

Name: pred_alu_pipe

Overview:
- Parametrised, pipelined predicate unit for the exec stage.
- Owns the predicate register file (NUM_PRED 1-bit regs; p0 hard-wired true).
- Evaluates logical ops on predicate regs and signed/unsigned compares on DATA_W operands, with one valid/ready output stage.
- Retired results write back into the file; the whole file is exported to issue logic for instruction predication.

Parameters:
- DATA_W, 32, width of srcA/srcB compare operands.
- NUM_PRED, 8, number of predicate registers, >=2.
- PIDX_W, 3, predicate index width; must equal clog2(NUM_PRED).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  request present.
- in_ready  out  1  unit can accept this cycle.
- pred_op  in  4  operation code, see Behaviour.
- srcA  in  DATA_W  compare operand A.
- srcB  in  DATA_W  compare operand B.
- psrcA  in  PIDX_W  predicate source A index.
- psrcB  in  PIDX_W  predicate source B index.
- pdst  in  PIDX_W  predicate destination index.
- out_valid  out  1  result held in stage register.
- out_ready  in  1  consumer accepts result.
- out_result  out  1  computed predicate bit.
- out_dst  out  PIDX_W  destination of held result.
- out_wr  out  1  held result will write the file on retire.
- out_illegal  out  1  held op was reserved.
- pred_file  out  NUM_PRED  current register file contents; bit 0 is always 1.

Behaviour:
- Reset (async, any time, including mid-transfer):
  - pred_file = {NUM_PRED-1 zeros, 1}.
  - out_valid=0, out_result=0, out_dst=0, out_wr=0, out_illegal=0.
  - Any in-flight result is discarded and is not written.
- Accept: in_valid && in_ready at a rising edge.
  - in_ready = !out_valid || out_ready, except for the hazard stall (see Optional Feature).
  - in_ready depends combinationally on out_ready; this is a 1-deep pipe, no skid buffer.
- Latency: result appears on out_* the cycle after accept.
  - Output fields are held stable while out_valid && !out_ready.
- Retire: out_valid && out_ready at an edge.
  - If out_wr, pred_file[out_dst] <= out_result at that edge.
  - A simultaneous accept loads the new op into the stage.
- Operand predicates pa/pb:
  - Read from pred_file[psrcA]/[psrcB]; index 0 reads 1.
  - With bypass (see Optional Feature): if out_valid && out_wr && out_dst==index && index!=0, use out_result instead. This applies even if that result retires the same cycle.
- Operations (result, write):
  - 0 NOP: result 0, no write.
  - 1 AND: pa&pb.
  - 2 OR: pa|pb.
  - 3 XOR: pa^pb.
  - 4 NOT: ~pa.
  - 5 LTZ: signed srcA<0, i.e. srcA[DATA_W-1].
  - 6 EQZ: srcA==0.
  - 7 EQ: srcA==srcB.
  - 8 NE: srcA!=srcB.
  - 9 LT: signed srcA<srcB.
  - 10 LTU: unsigned srcA<srcB.
  - 11 GE: signed srcA>=srcB.
  - 12 GEU: unsigned srcA>=srcB.
  - 13-15 reserved: result 0, no write, out_illegal=1.
- out_wr = 1 for ops 1-12 with pdst!=0; writes to p0 are suppressed (out_wr=0) and p0 stays 1.
- Back-to-back dependent ops sustain 1 op/cycle with bypass; ops with no dependence always sustain 1 op/cycle.

Optional Feature:
- Macro: PRED_BYPASS_EN.
- Defined: the S1 to operand forwarding above is implemented and no hazard stall exists.
- Undefined:
  - No forwarding; operands are read only from pred_file.
  - in_ready is forced 0 while in_valid && out_valid && out_wr && out_dst!=0 && pred_op in 1..4 && (out_dst==psrcA || (pred_op in 1..3 && out_dst==psrcB)).
  - The stall releases the cycle after the producer retires.
  - The result sequence is identical to the bypassed build; only throughput differs.

Test Plan:
- Reset then idle -> pred_file=8'h01, out_valid=0, in_ready=1. Assert rst mid-stall with out_valid=1 -> file returns to 8'h01 with no write.
- LT srcA=32'hFFFFFFFF, srcB=1, pdst=2; then LTU with same operands, pdst=3 -> out_result 1 then 0; after both retire pred_file=8'h05.
- LTZ srcA=32'h80000000, pdst=1; EQZ srcA=0, pdst=0 -> results 1 and 1; second has out_wr=0; pred_file[0] stays 1, pred_file=8'h03.
- Back-to-back EQ srcA=srcB=5 into p4, then AND psrcA=4, psrcB=0 into p5, out_ready held 1 -> with PRED_BYPASS_EN AND result 1 one cycle later, no bubble; without the macro in_ready=0 for exactly one cycle, same results.
- out_ready=0 for 3 cycles with a result held -> out_* stable, in_ready=0, file unchanged until retire.
- pred_op=14 -> out_illegal=1, out_result=0, out_wr=0, file unchanged; next op clears out_illegal.

Source files
------------

// File: rtl/pred_alu_pipe.sv
`default_nettype none
// ============================================================================
// Module   : pred_alu_pipe
// Brief    : Predicate register file with a one-stage predicate/compare unit.
//            Define PRED_BYPASS_EN to forward the staged result to operands;
//            without it, dependent predicate ops stall until the producer retires.
// Revision : 1.0 - initial release
// ============================================================================
module pred_alu_pipe #(
    parameter int DATA_W   = 32,
    parameter int NUM_PRED = 8,
    parameter int PIDX_W   = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [3:0]          pred_op,
    input  logic [DATA_W-1:0]   srcA,
    input  logic [DATA_W-1:0]   srcB,
    input  logic [PIDX_W-1:0]   psrcA,
    input  logic [PIDX_W-1:0]   psrcB,
    input  logic [PIDX_W-1:0]   pdst,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                out_result,
    output logic [PIDX_W-1:0]   out_dst,
    output logic                out_wr,
    output logic                out_illegal,
    output logic [NUM_PRED-1:0] pred_file
);

    localparam logic [3:0] c_op_nop = 4'd0;
    localparam logic [3:0] c_op_and = 4'd1;
    localparam logic [3:0] c_op_or  = 4'd2;
    localparam logic [3:0] c_op_xor = 4'd3;
    localparam logic [3:0] c_op_not = 4'd4;
    localparam logic [3:0] c_op_ltz = 4'd5;
    localparam logic [3:0] c_op_eqz = 4'd6;
    localparam logic [3:0] c_op_eq  = 4'd7;
    localparam logic [3:0] c_op_ne  = 4'd8;
    localparam logic [3:0] c_op_lt  = 4'd9;
    localparam logic [3:0] c_op_ltu = 4'd10;
    localparam logic [3:0] c_op_ge  = 4'd11;
    localparam logic [3:0] c_op_geu = 4'd12;

    logic                r_out_valid;
    logic                r_out_result;
    logic [PIDX_W-1:0]   r_out_dst;
    logic                r_out_wr;
    logic                r_out_illegal;
    logic [NUM_PRED-1:1] r_pred;

    logic [NUM_PRED-1:0] w_file;
    logic                w_pa;
    logic                w_pb;
    logic                w_stall;
    logic                w_result;
    logic                w_known_op;
    logic                w_illegal;
    logic                w_wr;
    logic                w_accept;
    logic                w_retire;

    // p0 is not stored; it always reads as 1.
    assign w_file = {r_pred, 1'b1};

    // Out-of-range indices (NUM_PRED not a power of two) read as 0.
    function automatic logic read_pred(input logic [PIDX_W-1:0] idx,
                                       input logic [NUM_PRED-1:0] file);
        logic v;
        v = 1'b0;
        for (int i = 0; i < NUM_PRED; i++) begin
            if (idx == PIDX_W'(i)) v = file[i];
        end
        return v;
    endfunction

`ifdef PRED_BYPASS_EN
    always_comb begin
        w_pa = read_pred(psrcA, w_file);
        w_pb = read_pred(psrcB, w_file);
        if (r_out_valid && r_out_wr && (r_out_dst == psrcA) && (psrcA != '0)) w_pa = r_out_result;
        if (r_out_valid && r_out_wr && (r_out_dst == psrcB) && (psrcB != '0)) w_pb = r_out_result;
    end
    assign w_stall = 1'b0;
`else
    assign w_pa = read_pred(psrcA, w_file);
    assign w_pb = read_pred(psrcB, w_file);
    // Only predicate-reading ops can depend on the staged result; NOT uses pa only.
    assign w_stall = in_valid && r_out_valid && r_out_wr && (r_out_dst != '0)
                   && (pred_op >= c_op_and) && (pred_op <= c_op_not)
                   && ((r_out_dst == psrcA)
                       || ((pred_op <= c_op_xor) && (r_out_dst == psrcB)));
`endif

    always_comb begin
        w_result   = 1'b0;
        w_known_op = 1'b1;
        w_illegal  = 1'b0;
        case (pred_op)
            c_op_nop: w_known_op = 1'b0;
            c_op_and: w_result = w_pa & w_pb;
            c_op_or:  w_result = w_pa | w_pb;
            c_op_xor: w_result = w_pa ^ w_pb;
            c_op_not: w_result = ~w_pa;
            c_op_ltz: w_result = srcA[DATA_W-1];
            c_op_eqz: w_result = (srcA == '0);
            c_op_eq:  w_result = (srcA == srcB);
            c_op_ne:  w_result = (srcA != srcB);
            c_op_lt:  w_result = ($signed(srcA) < $signed(srcB));
            c_op_ltu: w_result = (srcA < srcB);
            c_op_ge:  w_result = ($signed(srcA) >= $signed(srcB));
            c_op_geu: w_result = (srcA >= srcB);
            default: begin
                w_known_op = 1'b0;
                w_illegal  = 1'b1;
            end
        endcase
    end

    assign w_wr     = w_known_op && (pdst != '0);
    assign in_ready = (!r_out_valid || out_ready) && !w_stall;
    assign w_accept = in_valid && in_ready;
    assign w_retire = r_out_valid && out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_valid   <= 1'b0;
            r_out_result  <= 1'b0;
            r_out_dst     <= '0;
            r_out_wr      <= 1'b0;
            r_out_illegal <= 1'b0;
        end else if (w_accept) begin
            r_out_valid   <= 1'b1;
            r_out_result  <= w_result;
            r_out_dst     <= pdst;
            r_out_wr      <= w_wr;
            r_out_illegal <= w_illegal;
        end else if (w_retire) begin
            r_out_valid   <= 1'b0;
        end
    end

    genvar gi;
    generate
        for (gi = 1; gi < NUM_PRED; gi++) begin : g_pred_reg
            localparam logic [PIDX_W-1:0] c_idx = PIDX_W'(gi);
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_pred[gi] <= 1'b0;
                end else if (w_retire && r_out_wr && (r_out_dst == c_idx)) begin
                    r_pred[gi] <= r_out_result;
                end
            end
        end
    endgenerate

    assign out_valid   = r_out_valid;
    assign out_result  = r_out_result;
    assign out_dst     = r_out_dst;
    assign out_wr      = r_out_wr;
    assign out_illegal = r_out_illegal;
    assign pred_file   = w_file;

endmodule
`default_nettype wire

// File: tb/tb_pred_alu_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_pred_alu_pipe
// Brief    : Directed and randomized bench for pred_alu_pipe against an
//            in-order architectural model of the predicate file.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pred_alu_pipe;

    localparam int DATA_W   = 32;
    localparam int NUM_PRED = 8;
    localparam int PIDX_W   = 3;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                in_valid = 1'b0;
    logic                in_ready;
    logic [3:0]          pred_op = '0;
    logic [DATA_W-1:0]   srcA = '0;
    logic [DATA_W-1:0]   srcB = '0;
    logic [PIDX_W-1:0]   psrcA = '0;
    logic [PIDX_W-1:0]   psrcB = '0;
    logic [PIDX_W-1:0]   pdst = '0;
    logic                out_valid;
    logic                out_ready = 1'b0;
    logic                out_result;
    logic [PIDX_W-1:0]   out_dst;
    logic                out_wr;
    logic                out_illegal;
    logic [NUM_PRED-1:0] pred_file;

    pred_alu_pipe #(.DATA_W(DATA_W), .NUM_PRED(NUM_PRED), .PIDX_W(PIDX_W)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .pred_op(pred_op),
        .srcA(srcA), .srcB(srcB), .psrcA(psrcA), .psrcB(psrcB), .pdst(pdst),
        .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
        .out_dst(out_dst), .out_wr(out_wr), .out_illegal(out_illegal),
        .pred_file(pred_file)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // m_arch: file as if every accepted op had executed in order.
    // m_comm: file as visible after retirement. m_*: the op held in the stage.
    bit [NUM_PRED-1:0] m_arch;
    bit [NUM_PRED-1:0] m_comm;
    bit                m_pend;
    bit                m_res;
    bit                m_wr;
    bit                m_ill;
    bit [PIDX_W-1:0]   m_dst;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic bit model_eval(input bit [3:0] op, input bit [31:0] a, input bit [31:0] b,
                                      input bit pa, input bit pb);
        case (op)
            1:  return pa & pb;
            2:  return pa | pb;
            3:  return pa ^ pb;
            4:  return !pa;
            5:  return $signed(a) < 0;
            6:  return a == 0;
            7:  return a == b;
            8:  return a != b;
            9:  return $signed(a) < $signed(b);
            10: return a < b;
            11: return $signed(a) >= $signed(b);
            12: return a >= b;
            default: return 1'b0;
        endcase
    endfunction

    task automatic model_reset();
        m_arch = 1;
        m_comm = 1;
        m_pend = 0;
        m_res  = 0;
        m_wr   = 0;
        m_ill  = 0;
        m_dst  = 0;
    endtask

    // One clock cycle, entered and left at posedge+1.
    task automatic step(input bit v, input bit [3:0] op, input bit [31:0] a, input bit [31:0] b,
                        input bit [2:0] ia, input bit [2:0] ib, input bit [2:0] id, input bit ordy,
                        output bit acc, output bit obs_ready);
        bit hazard, exp_ready, ret, r, w;
        in_valid = v; pred_op = op; srcA = a; srcB = b;
        psrcA = ia; psrcB = ib; pdst = id; out_ready = ordy;
        @(negedge clk);
        hazard = 0;
`ifndef PRED_BYPASS_EN
        hazard = v && m_pend && m_wr && (op >= 1) && (op <= 4)
               && (m_dst == ia || (op <= 3 && m_dst == ib));
`endif
        exp_ready = (!m_pend || ordy) && !hazard;
        obs_ready = in_ready;
        check("in_ready", in_ready, exp_ready);
        check("out_valid", out_valid, m_pend);
        if (m_pend) begin
            check("out_result", out_result, m_res);
            check("out_dst", out_dst, m_dst);
            check("out_wr", out_wr, m_wr);
            check("out_illegal", out_illegal, m_ill);
        end
        check("pred_file", pred_file, m_comm);
        ret = m_pend && ordy;
        acc = v && exp_ready;
        if (ret) begin
            if (m_wr) m_comm[m_dst] = m_res;
            m_pend = 0;
        end
        if (acc) begin
            r = model_eval(op, a, b, m_arch[ia], m_arch[ib]);
            w = (op >= 1) && (op <= 12) && (id != 0);
            m_pend = 1;
            m_res  = r;
            m_wr   = w;
            m_ill  = (op >= 13);
            m_dst  = id;
            if (w) m_arch[id] = r;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        bit acc, rdy;
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 1, acc, rdy);
    endtask

    // Asserts reset between clock edges to exercise the asynchronous path.
    task automatic do_reset();
        in_valid = 0;
        #2;
        rst = 1;
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_out_result", out_result, 0);
        check("rst_out_dst", out_dst, 0);
        check("rst_out_wr", out_wr, 0);
        check("rst_out_illegal", out_illegal, 0);
        check("rst_pred_file", pred_file, 8'h01);
        model_reset();
        @(posedge clk);
        #1;
        rst = 0;
    endtask

    initial begin
        bit acc, rdy;
        int stalls;
        bit [31:0] a, b;
        model_reset();
        @(posedge clk);
        #1;
        do_reset();
        idle(2);

        // Signed vs unsigned compare of -1 and 1.
        step(1, 9, 32'hFFFFFFFF, 1, 0, 0, 2, 1, acc, rdy);
        step(1, 10, 32'hFFFFFFFF, 1, 0, 0, 3, 1, acc, rdy);
        idle(2);
        check("lt_ltu_file", pred_file, 8'h05);

        // Writes to p0 are dropped.
        do_reset();
        step(1, 5, 32'h80000000, 0, 0, 0, 1, 1, acc, rdy);
        step(1, 6, 0, 0, 0, 0, 0, 1, acc, rdy);
        idle(2);
        check("ltz_eqz_file", pred_file, 8'h03);

        // Dependent back-to-back: EQ -> p4, AND p4,p0 -> p5.
        step(1, 7, 5, 5, 0, 0, 4, 1, acc, rdy);
        stalls = 0;
        for (int i = 0; i < 4; i++) begin
            step(1, 1, 0, 0, 4, 0, 5, 1, acc, rdy);
            if (!rdy) stalls++;
            if (acc) break;
        end
        idle(2);
        check("dep_p5", pred_file[5], 1);
`ifdef PRED_BYPASS_EN
        check("dep_stalls", stalls, 0);
`else
        check("dep_stalls", stalls, 1);
`endif

        // Held result under back-pressure.
        step(1, 7, 3, 3, 0, 0, 6, 0, acc, rdy);
        for (int i = 0; i < 3; i++) step(1, 8, 1, 2, 0, 0, 7, 0, acc, rdy);
        check("hold_file", pred_file, 8'h33);
        step(1, 8, 1, 2, 0, 0, 7, 1, acc, rdy);
        idle(2);
        check("hold_after_file", pred_file, 8'hF3);

        // Reserved op, then a NOP that clears out_illegal.
        step(1, 14, 1, 1, 0, 0, 3, 1, acc, rdy);
        step(1, 0, 0, 0, 0, 0, 3, 1, acc, rdy);
        idle(1);
        check("illegal_file", pred_file, 8'hF3);

        // Reset while a result is held and stalled.
        step(1, 8, 1, 1, 0, 0, 6, 0, acc, rdy);
        step(1, 1, 0, 0, 6, 6, 2, 0, acc, rdy);
        do_reset();
        idle(1);

        // Randomized traffic with dependence-rich register indices.
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 299) == 0) begin
                do_reset();
            end else begin
                a = $urandom;
                b = $urandom;
                case ($urandom_range(0, 3))
                    0: b = a;
                    1: a = 0;
                    2: begin a = $urandom_range(0, 3) - 2; b = $urandom_range(0, 3) - 2; end
                    default: ;
                endcase
                step($urandom_range(0, 3) != 0, 4'($urandom_range(0, 15)), a, b,
                     3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                     3'($urandom_range(0, 7)), $urandom_range(0, 3) != 0, acc, rdy);
            end
        end
        idle(3);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
